// File: rtl/mem_bus_pkg.sv
// Shared types for the cache-line memory port arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam int unsigned LINE_BYTES = 64;

  // Map a one-hot grant vector (bit0 = icache, bit1 = dcache) to an owner.
  function automatic owner_t grant_to_owner(input logic [1:0] grant);
    return grant[1] ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a sole requester wins, a tie goes to the
// requester that did not win last time.
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last_grant,
  output logic [1:0] grant
);

  // Combinational winner selection.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_grant == OWN_D) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache-line memory bus port between the icache and the dcache.
// One transaction in flight, round-robin grants, watchdog on the WAIT phase.
module mem_port_arbiter
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned LINE_W      = 512,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  output logic              i_reqack,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_done,
  input  logic              d_req,
  output logic              d_reqack,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_we,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_done,
  output logic              bus_req,
  input  logic              bus_reqack,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [LINE_W-1:0] bus_wdata,
  input  logic [LINE_W-1:0] bus_rdata,
  input  logic              bus_done,
  output logic              timeout_err
);

  // Watchdog counter sized for TIMEOUT_CYC-1; a zero TIMEOUT_CYC disables it.
  localparam int unsigned     WD_W    = (TIMEOUT_CYC > 32'd2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic            WD_ON   = (TIMEOUT_CYC != 32'd0);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYC == 32'd0) ? 32'd0 : TIMEOUT_CYC - 32'd1);

  arb_state_t        state, state_nx;
  owner_t            owner, owner_nx;
  owner_t            last_grant, last_grant_nx;
  logic [1:0]        grant;
  logic [WD_W-1:0]   wd_cnt, wd_cnt_nx;

  logic              bus_req_nx;
  logic [ADDR_W-1:0] bus_addr_nx;
  logic              bus_we_nx;
  logic [LINE_W-1:0] bus_wdata_nx;
  logic [LINE_W-1:0] i_rdata_nx, d_rdata_nx;
  logic              i_reqack_nx, d_reqack_nx;
  logic              i_done_nx, d_done_nx;
  logic              timeout_err_nx;

  // Per-cycle events routed to the current owner after the state decode.
  logic              accept;
  logic              finish;
  logic [LINE_W-1:0] finish_data;

  rr_arb2 u_rr_arb2 (
    .req        ({d_req, i_req}),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Next-state and next-output decode for the grant/issue/wait/done sequence.
  always_comb begin
    state_nx       = state;
    owner_nx       = owner;
    last_grant_nx  = last_grant;
    wd_cnt_nx      = wd_cnt;
    bus_req_nx     = bus_req;
    bus_addr_nx    = bus_addr;
    bus_we_nx      = bus_we;
    bus_wdata_nx   = bus_wdata;
    timeout_err_nx = 1'b0;
    accept         = 1'b0;
    finish         = 1'b0;
    finish_data    = {LINE_W{1'b0}};

    case (state)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          owner_nx      = grant_to_owner(grant);
          last_grant_nx = grant_to_owner(grant);
          bus_req_nx    = 1'b1;
          state_nx      = ST_ISSUE;
          if (grant_to_owner(grant) == OWN_D) begin
            bus_addr_nx  = d_addr;
            bus_we_nx    = d_we;
            bus_wdata_nx = d_wdata;
          end else begin
            // The icache only ever fills lines.
            bus_addr_nx  = i_addr;
            bus_we_nx    = 1'b0;
            bus_wdata_nx = {LINE_W{1'b0}};
          end
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (bus_reqack) begin
          accept     = 1'b1;
          bus_req_nx = 1'b0;
          wd_cnt_nx  = {WD_W{1'b0}};
          if (bus_done) begin
            // Bus finished in the same cycle it accepted: skip WAIT.
            finish      = 1'b1;
            finish_data = bus_rdata;
            state_nx    = ST_DONE;
          end else begin
            state_nx = ST_WAIT;
          end
        end else begin
          bus_req_nx = 1'b1;
        end
      end
      ST_WAIT: begin
        if (bus_done) begin
          finish      = 1'b1;
          finish_data = bus_rdata;
          state_nx    = ST_DONE;
        end else if (WD_ON && (wd_cnt == WD_LAST)) begin
          // Bus never answered: release the requester with an empty line.
          finish         = 1'b1;
          finish_data    = {LINE_W{1'b0}};
          timeout_err_nx = 1'b1;
          state_nx       = ST_IDLE;
        end else begin
          wd_cnt_nx = wd_cnt + WD_W'(1);
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    i_reqack_nx = accept && (owner == OWN_I);
    d_reqack_nx = accept && (owner == OWN_D);
    i_done_nx   = finish && (owner == OWN_I);
    d_done_nx   = finish && (owner == OWN_D);
    i_rdata_nx  = (finish && (owner == OWN_I)) ? finish_data : i_rdata;
    d_rdata_nx  = (finish && (owner == OWN_D)) ? finish_data : d_rdata;
  end

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      owner       <= OWN_I;
      last_grant  <= OWN_D;
      wd_cnt      <= {WD_W{1'b0}};
      bus_req     <= 1'b0;
      bus_addr    <= {ADDR_W{1'b0}};
      bus_we      <= 1'b0;
      bus_wdata   <= {LINE_W{1'b0}};
      i_rdata     <= {LINE_W{1'b0}};
      d_rdata     <= {LINE_W{1'b0}};
      i_reqack    <= 1'b0;
      d_reqack    <= 1'b0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      owner       <= owner_nx;
      last_grant  <= last_grant_nx;
      wd_cnt      <= wd_cnt_nx;
      bus_req     <= bus_req_nx;
      bus_addr    <= bus_addr_nx;
      bus_we      <= bus_we_nx;
      bus_wdata   <= bus_wdata_nx;
      i_rdata     <= i_rdata_nx;
      d_rdata     <= d_rdata_nx;
      i_reqack    <= i_reqack_nx;
      d_reqack    <= d_reqack_nx;
      i_done      <= i_done_nx;
      d_done      <= d_done_nx;
      timeout_err <= timeout_err_nx;
    end
  end

endmodule
